// File: rtl/reg_bank_dump_loader_if.sv
// Bus bundle between reg_bank_dump_loader (master side) and the register bank
// plus the two word streams (slave side).
//
// Stream handshake rule (both the dump stream outData/outValid/outReady and the
// load stream inData/inValid/inReady): a word moves on a rising clk edge where
// valid and ready are both high. Once valid is raised, the sender holds valid
// and data unchanged until that edge. Ready may change freely.
interface reg_bank_dump_loader_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    logic              startDump;
    logic              startLoad;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] readReg;
    logic [DATA_W-1:0] RegData;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [DATA_W-1:0] outData;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] inData;
    logic              inValid;
    logic              inReady;
    logic [DATA_W-1:0] checksum;

    modport master (
        input  startDump, startLoad, RegData, outReady, inData, inValid,
        output busy, done, readReg, regWrite, writeReg, writeData,
               outData, outValid, inReady, checksum
    );

    modport slave (
        output startDump, startLoad, RegData, outReady, inData, inValid,
        input  busy, done, readReg, regWrite, writeReg, writeData,
               outData, outValid, inReady, checksum
    );
endinterface

// File: rtl/reg_bank_dump_loader.sv
// reg_bank_dump_loader: walks register indices FIRST_REG..LAST_REG of the
// register bank, either streaming their contents out (dump) or writing words
// taken from an input stream into them (load).
// Optional feature: define REGDUMP_CHECKSUM_EN to enable the running XOR
// checksum of transferred words; otherwise the checksum port is tied to 0.
// The FSM state is exposed on dbg_state.
module reg_bank_dump_loader #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic                   clk,
    input  logic                   rst_n,
    reg_bank_dump_loader_if.master bus,
    output logic [2:0]             dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAPT  = 3'd2,
        RD_SEND  = 3'd3,
        LD_WAIT  = 3'd4,
        LD_WRITE = 3'd5,
        FIN      = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] write_data;
    logic              at_last;
    logic              dump_hs;
    logic              load_hs;
    logic              dump_phase;

    assign at_last    = (idx == LAST_IDX);
    assign dump_hs    = (state == RD_SEND) && bus.outReady;
    assign load_hs    = (state == LD_WAIT) && bus.inValid;
    assign dump_phase = (state == RD_ISSUE) || (state == RD_CAPT) || (state == RD_SEND);

    // State register; reset aborts any transfer in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; dump wins when both starts arrive together, and
    // starts seen outside IDLE are dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.startDump)      state_next = RD_ISSUE;
                else if (bus.startLoad) state_next = LD_WAIT;
            end
            RD_ISSUE: state_next = RD_CAPT;
            RD_CAPT:  state_next = RD_SEND;
            RD_SEND: begin
                if (bus.outReady) state_next = at_last ? FIN : RD_ISSUE;
            end
            LD_WAIT: begin
                if (bus.inValid) state_next = LD_WRITE;
            end
            LD_WRITE: state_next = at_last ? FIN : LD_WAIT;
            FIN:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Register index: parked at FIRST_REG in IDLE, advanced after each word,
    // never moved past LAST_REG.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx <= FIRST_IDX;
        end else if (state == IDLE) begin
            idx <= FIRST_IDX;
        end else if ((dump_hs || (state == LD_WRITE)) && !at_last) begin
            idx <= idx + 1'b1;
        end
    end

    // Capture bank read data one cycle after the index was presented; the
    // word then stays put until the next capture.
    always_ff @(posedge clk) begin
        if (!rst_n)                out_data <= '0;
        else if (state == RD_CAPT) out_data <= bus.RegData;
    end

    // Capture the accepted load word; it feeds writeData in LD_WRITE and
    // is held afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n)       write_data <= '0;
        else if (load_hs) write_data <= bus.inData;
    end

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q;
    logic              start_accept;

    assign start_accept = (state == IDLE) && (bus.startDump || bus.startLoad);

    // Running XOR of every word moved: cleared on an accepted start, then
    // left untouched from done until the next start.
    always_ff @(posedge clk) begin
        if (!rst_n)            checksum_q <= '0;
        else if (start_accept) checksum_q <= '0;
        else if (dump_hs)      checksum_q <= checksum_q ^ out_data;
        else if (load_hs)      checksum_q <= checksum_q ^ bus.inData;
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = '0;
`endif

    // Every control output is decoded from the registered state, so reset
    // forces them all low on the next edge.
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.readReg   = dump_phase ? idx : '0;
    assign bus.outValid  = (state == RD_SEND);
    assign bus.outData   = out_data;
    assign bus.inReady   = (state == LD_WAIT);
    assign bus.regWrite  = (state == LD_WRITE);
    assign bus.writeReg  = (state == LD_WRITE) ? idx : '0;
    assign bus.writeData = write_data;
    assign dbg_state     = state;

endmodule

// File: tb/tb_reg_bank_dump_loader.sv
// Bench for reg_bank_dump_loader: a table of dump/load runs checked against a
// spec-level model of the register bank, plus hand-written reset-abort and
// single-register sequences. Define REGDUMP_CHECKSUM_EN to build the checksum
// variant; the expected checksum follows the same macro.
module tb_reg_bank_dump_loader;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int N  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] dbg_state;
    logic [2:0] dbg_state1;

    reg_bank_dump_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    reg_bank_dump_loader_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    reg_bank_dump_loader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
    );

    // Second instance covering a one-register range.
    reg_bank_dump_loader #(.DATA_W(DW), .ADDR_W(AW), .FIRST_REG(7), .LAST_REG(7)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg_state1)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- register bank environment ----------------
    logic [DW-1:0] bank [N];
    logic [DW-1:0] image [N];
    logic          load_image = 1'b0;

    always @(posedge clk) begin
        bus.RegData <= bank[bus.readReg];
        if (load_image) begin
            for (int i = 0; i < N; i++) bank[i] <= image[i];
        end else if (bus.regWrite) begin
            bank[bus.writeReg] <= bus.writeData;
        end
    end

    always @(posedge clk) bus1.RegData <= 64'hA5A5_0000_0000_0000 | 64'(bus1.readReg);

    // ---------------- model / scoreboard state ----------------
    logic [DW-1:0] model_bank [N];
    logic [DW-1:0] ld_data [N];
    int tests = 0;
    int fails = 0;

    typedef struct {
        bit            is_load;
        bit            both;
        bit            mid_start;
        int            stall_word;
        int            stall_len;
        bit            rnd_hs;
        int            pattern;
        int            exp_cycles;
        bit            fixed_cks;
        logic [DW-1:0] exp_cks;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit is_load, bit both, bit mid, int sw, int sl, bit rnd,
                                int pat, int cyc, bit fx, logic [DW-1:0] c);
        vec_t v;
        v.is_load = is_load; v.both = both; v.mid_start = mid;
        v.stall_word = sw; v.stall_len = sl; v.rnd_hs = rnd;
        v.pattern = pat; v.exp_cycles = cyc; v.fixed_cks = fx; v.exp_cks = c;
        return v;
    endfunction

    // Patterns: 0 i*1111, 1 ~i, 2 random, 3 i, 4 only reg5=1.
    function automatic logic [DW-1:0] gen_word(input int p, input int i);
        logic [DW-1:0] w;
        case (p)
            0:       w = 64'(i) * 64'h1111;
            1:       w = ~64'(i);
            2:       w = {$urandom(), $urandom()};
            3:       w = 64'(i);
            default: w = (i == 5) ? 64'h1 : 64'h0;
        endcase
        return w;
    endfunction

    function automatic logic [DW-1:0] cks_expect(input vec_t v, input logic [DW-1:0] m);
        logic [DW-1:0] r;
        r = v.fixed_cks ? v.exp_cks : m;
`ifndef REGDUMP_CHECKSUM_EN
        r = '0;
`endif
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic preload(input int p);
        for (int i = 0; i < N; i++) begin
            image[i] = gen_word(p, i);
            model_bank[i] = image[i];
        end
        @(negedge clk);
        load_image = 1'b1;
        @(negedge clk);
        load_image = 1'b0;
    endtask

    task automatic run_dump(input vec_t v);
        logic [DW-1:0] exp_q[$];
        logic [DW-1:0] model_cks = '0;
        logic [DW-1:0] prev_data = '0;
        logic [DW-1:0] done_cks = '0;
        logic prev_hold = 1'b0;
        logic ready;
        int cyc = 1;
        int done_cyc = 0;
        int word = 0;
        int stall = 0;
        int viol = 0;
        for (int i = 0; i < N; i++) begin
            exp_q.push_back(model_bank[i]);
            model_cks ^= model_bank[i];
        end
        @(negedge clk);
        check("dump_idle_busy", bus.busy, 0);
        bus.startDump = 1'b1;
        bus.startLoad = v.both;
        @(negedge clk);
        bus.startDump = 1'b0;
        bus.startLoad = 1'b0;
        check("dump_busy_rise", bus.busy, 1);
        while (done_cyc == 0 && cyc < 2000) begin
            bus.startLoad = v.mid_start && (cyc == 10);
            if (bus.regWrite || bus.inReady) viol++;
            if (prev_hold) begin
                check("dump_hold_valid", bus.outValid, 1);
                check("dump_hold_data", bus.outData, prev_data);
            end
            if (bus.outValid && word == v.stall_word && stall < v.stall_len) begin
                ready = 1'b0;
                stall++;
            end else if (v.rnd_hs) begin
                ready = 1'($urandom_range(0, 1));
            end else begin
                ready = 1'b1;
            end
            bus.outReady = ready;
            if (bus.outValid && ready) begin
                if (exp_q.size() == 0) check("dump_extra_word", 1, 0);
                else check("dump_word", bus.outData, exp_q.pop_front());
                word++;
            end
            prev_hold = bus.outValid && !ready;
            prev_data = bus.outData;
            if (bus.done) begin
                done_cyc = cyc;
                done_cks = bus.checksum;
                check("dump_words_left", 64'(exp_q.size()), 0);
                check("dump_checksum", bus.checksum, cks_expect(v, model_cks));
            end
            @(negedge clk);
            cyc++;
        end
        bus.outReady = 1'b0;
        bus.startLoad = 1'b0;
        if (done_cyc == 0) check("dump_timeout", 0, 1);
        if (v.exp_cycles != 0) check("dump_cycles", 64'(done_cyc), 64'(v.exp_cycles));
        check("dump_busy_drop", bus.busy, 0);
        check("dump_done_once", bus.done, 0);
        check("dump_cks_stable", bus.checksum, done_cks);
        check("dump_no_write", 64'(viol), 0);
    endtask

    task automatic run_load(input vec_t v);
        logic [DW-1:0] wq[$];
        int iq[$];
        logic [DW-1:0] model_cks = '0;
        logic valid;
        int accepted = 0;
        int writes = 0;
        int cyc = 1;
        int done_cyc = 0;
        int viol = 0;
        @(negedge clk);
        check("load_idle_busy", bus.busy, 0);
        bus.startLoad = 1'b1;
        @(negedge clk);
        bus.startLoad = 1'b0;
        check("load_busy_rise", bus.busy, 1);
        while (done_cyc == 0 && cyc < 2000) begin
            if (bus.outValid) viol++;
            if (bus.regWrite) begin
                writes++;
                if (wq.size() == 0) begin
                    check("load_extra_write", 1, 0);
                end else begin
                    check("load_wreg", 64'(bus.writeReg), 64'(iq.pop_front()));
                    check("load_wdata", bus.writeData, wq.pop_front());
                end
            end
            valid = (accepted < N) && (v.rnd_hs ? ($urandom_range(0, 1) == 1) : 1'b1);
            bus.inValid = valid;
            bus.inData = ld_data[accepted % N];
            if (valid && bus.inReady) begin
                wq.push_back(ld_data[accepted]);
                iq.push_back(accepted);
                model_cks ^= ld_data[accepted];
                model_bank[accepted] = ld_data[accepted];
                accepted++;
            end
            if (bus.done) begin
                done_cyc = cyc;
                check("load_pending", 64'(wq.size()), 0);
                check("load_write_count", 64'(writes), 64'(N));
                check("load_checksum", bus.checksum, cks_expect(v, model_cks));
            end
            @(negedge clk);
            cyc++;
        end
        bus.inValid = 1'b0;
        if (done_cyc == 0) check("load_timeout", 0, 1);
        if (v.exp_cycles != 0) check("load_cycles", 64'(done_cyc), 64'(v.exp_cycles));
        check("load_busy_drop", bus.busy, 0);
        check("load_no_outvalid", 64'(viol), 0);
        for (int i = 0; i < N; i++) check("load_bank", bank[i], model_bank[i]);
    endtask

    // Load aborted by reset right after the write of register 10.
    task automatic run_abort_load();
        int writes = 0;
        int acc = 0;
        int cyc = 0;
        for (int i = 0; i < N; i++) ld_data[i] = gen_word(2, i);
        @(negedge clk);
        bus.startLoad = 1'b1;
        @(negedge clk);
        bus.startLoad = 1'b0;
        while (cyc < 500) begin
            if (bus.regWrite) writes++;
            if (writes == 11) break;
            bus.inValid = 1'b1;
            bus.inData = ld_data[acc % N];
            if (bus.inReady) acc++;
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_word10", 64'(writes), 11);
        rst_n = 1'b0;
        bus.inValid = 1'b1;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_regwrite", bus.regWrite, 0);
        check("abort_inready", bus.inReady, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.inValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort_regwrite_after", bus.regWrite, 0);
        end
        for (int k = 0; k <= 10; k++) model_bank[k] = ld_data[k];
        for (int i = 0; i < N; i++) check("abort_bank", bank[i], model_bank[i]);
    endtask

    // Dump aborted by reset while a word is waiting on outReady.
    task automatic run_abort_dump();
        int cyc = 0;
        bus.outReady = 1'b0;
        @(negedge clk);
        bus.startDump = 1'b1;
        @(negedge clk);
        bus.startDump = 1'b0;
        while (!bus.outValid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_dump_valid_seen", bus.outValid, 1);
        check("abort_dump_word0", bus.outData, model_bank[0]);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_dump_outvalid", bus.outValid, 0);
        check("abort_dump_outdata", bus.outData, 0);
        check("abort_dump_busy", bus.busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One-register range: one word each way, minimum latency.
    task automatic run_single_reg();
        int words = 0;
        int writes = 0;
        int done_cyc = 0;
        bus1.outReady = 1'b1;
        @(negedge clk);
        bus1.startDump = 1'b1;
        @(negedge clk);
        bus1.startDump = 1'b0;
        for (int c = 1; c < 20 && done_cyc == 0; c++) begin
            if (bus1.outValid) begin
                words++;
                check("single_dump_data", bus1.outData, 64'hA5A5_0000_0000_0007);
            end
            if (bus1.done) done_cyc = c;
            @(negedge clk);
        end
        check("single_dump_words", 64'(words), 1);
        check("single_dump_cycles", 64'(done_cyc), 4);
        bus1.outReady = 1'b0;
        done_cyc = 0;
        bus1.startLoad = 1'b1;
        bus1.inValid = 1'b1;
        bus1.inData = 64'hDEAD_BEEF_0123_4567;
        @(negedge clk);
        bus1.startLoad = 1'b0;
        for (int c = 1; c < 20 && done_cyc == 0; c++) begin
            if (bus1.regWrite) begin
                writes++;
                check("single_wreg", 64'(bus1.writeReg), 7);
                check("single_wdata", bus1.writeData, 64'hDEAD_BEEF_0123_4567);
            end
            if (bus1.done) done_cyc = c;
            @(negedge clk);
        end
        bus1.inValid = 1'b0;
        check("single_load_writes", 64'(writes), 1);
        check("single_load_cycles", 64'(done_cyc), 3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bus.startDump = 1'b0; bus.startLoad = 1'b0; bus.outReady = 1'b0;
        bus.inValid = 1'b0;   bus.inData = '0;
        bus1.startDump = 1'b0; bus1.startLoad = 1'b0; bus1.outReady = 1'b0;
        bus1.inValid = 1'b0;   bus1.inData = '0;
        for (int i = 0; i < N; i++) begin
            image[i] = '0;
            model_bank[i] = '0;
            ld_data[i] = '0;
        end

        //                  load both mid  sw  sl rnd pat cyc  fx  cks
        vecs[0] = mk(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 0, 97,  1'b0, 64'h0);
        vecs[1] = mk(1'b0, 1'b0, 1'b0,  3, 5, 1'b0, 5, 102, 1'b0, 64'h0);
        vecs[2] = mk(1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1, 65,  1'b0, 64'h0);
        vecs[3] = mk(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 5, 97,  1'b0, 64'h0);
        vecs[4] = mk(1'b0, 1'b1, 1'b0, -1, 0, 1'b0, 3, 97,  1'b1, 64'h0);
        vecs[5] = mk(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 4, 97,  1'b1, 64'h1);
        vecs[6] = mk(1'b0, 1'b0, 1'b1, -1, 0, 1'b1, 2, 0,   1'b0, 64'h0);
        vecs[7] = mk(1'b1, 1'b0, 1'b0, -1, 0, 1'b1, 2, 0,   1'b0, 64'h0);
        vecs[8] = mk(1'b0, 1'b0, 1'b0, -1, 0, 1'b1, 5, 0,   1'b0, 64'h0);

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_regwrite", bus.regWrite, 0);
        check("rst_outvalid", bus.outValid, 0);
        check("rst_inready", bus.inReady, 0);
        check("rst_outdata", bus.outData, 0);
        check("rst_writedata", bus.writeData, 0);
        check("rst_readreg", 64'(bus.readReg), 0);
        check("rst_writereg", 64'(bus.writeReg), 0);
        check("rst_checksum", bus.checksum, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_single_reg();

        for (int t = 0; t < 9; t++) begin
            if (vecs[t].is_load) begin
                for (int i = 0; i < N; i++) ld_data[i] = gen_word(vecs[t].pattern, i);
                run_load(vecs[t]);
            end else begin
                if (vecs[t].pattern != 5) preload(vecs[t].pattern);
                run_dump(vecs[t]);
            end
        end

        run_abort_load();
        run_abort_dump();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule
